// File: rtl/reg_bank.sv
// Parametrised CPU register bank: one write (or swap pair) per cycle, two direct-read ports, flags.
// Writes visible the cycle after the edge; DRIVE/read ports combinational; no backpressure.
module reg_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int SEL_WIDTH  = 4,
  parameter bit ZERO_REG0  = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            op,
  input  logic [SEL_WIDTH-1:0]  dst,
  input  logic [SEL_WIDTH-1:0]  src,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_oe,
  input  logic [SEL_WIDTH-1:0]  a_sel,
  input  logic [SEL_WIDTH-1:0]  b_sel,
  output logic [DATA_WIDTH-1:0] a_direct,
  output logic [DATA_WIDTH-1:0] b_direct,
  output logic                  zero_flag,
  output logic                  carry_flag,
  output logic                  idx_err
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_DRIVE = 3'd2,
    OP_INC   = 3'd3,
    OP_DEC   = 3'd4,
    OP_CLR   = 3'd5,
    OP_MOVE  = 3'd6,
    OP_SWAP  = 3'd7
  } op_e;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  function automatic logic in_range(input logic [SEL_WIDTH-1:0] idx);
    in_range = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == SEL_WIDTH'(i)) in_range = 1'b1;
  endfunction

  // Out-of-range indices and a hard-wired register 0 both read as zero.
  function automatic logic [DATA_WIDTH-1:0] rd(input logic [SEL_WIDTH-1:0] idx,
                                               input logic [DATA_WIDTH-1:0] arr [NUM_REGS]);
    rd = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == SEL_WIDTH'(i) && !(ZERO_REG0 && i == 0)) rd = arr[i];
  endfunction

  logic                  dst_ok, src_ok, err;
  logic                  wr_en, swap_en, flag_upd, new_carry;
  logic [DATA_WIDTH-1:0] dst_val, src_val, wr_val;

  always_comb begin
    dst_ok    = in_range(dst);
    src_ok    = in_range(src);
    dst_val   = rd(dst, regs);
    src_val   = rd(src, regs);
    err       = 1'b0;
    wr_en     = 1'b0;
    swap_en   = 1'b0;
    flag_upd  = 1'b0;
    new_carry = 1'b0;
    wr_val    = '0;
    case (op)
      OP_LOAD:  begin err = !dst_ok; wr_en = 1'b1; flag_upd = 1'b1; wr_val = bus_in; end
      OP_DRIVE: err = !src_ok;
      OP_INC: begin
        err = !dst_ok; wr_en = 1'b1; flag_upd = 1'b1;
        wr_val = dst_val + DATA_WIDTH'(1);
        new_carry = (dst_val == '1);
      end
      OP_DEC: begin
        err = !dst_ok; wr_en = 1'b1; flag_upd = 1'b1;
        wr_val = dst_val - DATA_WIDTH'(1);
        new_carry = (dst_val == '0);
      end
      OP_CLR:   begin err = !dst_ok; wr_en = 1'b1; flag_upd = 1'b1; end
      OP_MOVE:  begin err = !dst_ok || !src_ok; wr_en = 1'b1; flag_upd = 1'b1; wr_val = src_val; end
      OP_SWAP:  begin err = !dst_ok || !src_ok; swap_en = (dst != src); end
      default:  ;
    endcase
  end

  assign a_direct = rd(a_sel, regs);
  assign b_direct = rd(b_sel, regs);
  assign bus_oe   = (op == OP_DRIVE);
  assign bus_out  = bus_oe ? src_val : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      idx_err    <= 1'b0;
    end else begin
      idx_err <= err;
      if (flag_upd) begin
        zero_flag  <= (wr_val == '0);
        carry_flag <= new_carry;
      end
      // Any bad index on a used operand discards the whole write, swap included.
      if (!err) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (!(ZERO_REG0 && i == 0)) begin
            if (wr_en && dst == SEL_WIDTH'(i)) regs[i] <= wr_val;
            if (swap_en && dst == SEL_WIDTH'(i)) regs[i] <= src_val;
            if (swap_en && src == SEL_WIDTH'(i)) regs[i] <= dst_val;
          end
        end
      end
    end
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised register bank that replaces the fixed set of accumulator and temporary registers on the shared CPU bus.
- Holds NUM_REGS registers of DATA_WIDTH bits each.
- The control unit drives one operation per cycle: bus load, bus drive, increment, decrement, clear, move or swap.
- Two combinational direct-read ports feed the ALU operands. Registered zero and carry flags go back to the control unit.

Parameters:
DATA_WIDTH, 8, width of each register and of the bus
NUM_REGS, 4, number of registers (2..16)
SEL_WIDTH, 4, register index width; must satisfy 2**SEL_WIDTH >= NUM_REGS
ZERO_REG0, 0, when 1, register 0 is hard-wired to zero and writes to it are discarded

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
op  in  3  operation code, encoding given below
dst  in  SEL_WIDTH  destination register index
src  in  SEL_WIDTH  source register index
bus_in  in  DATA_WIDTH  shared bus value, sampled on LOAD
bus_out  out  DATA_WIDTH  value driven toward the bus
bus_oe  out  1  bus_out is valid and must be driven onto the bus
a_sel  in  SEL_WIDTH  direct-read port A index
b_sel  in  SEL_WIDTH  direct-read port B index
a_direct  out  DATA_WIDTH  combinational contents of reg[a_sel] (ALU register1)
b_direct  out  DATA_WIDTH  combinational contents of reg[b_sel] (ALU register2)
zero_flag  out  1  registered: last flag-updating result was zero
carry_flag  out  1  registered: last INC wrapped or last DEC borrowed
idx_err  out  1  registered one-cycle pulse: previous op used an out-of-range index

Behaviour:
- Reset: when reset==0 on a rising edge, all registers, zero_flag, carry_flag and idx_err clear to 0. Reset wins over any op issued in the same cycle.
- Op encoding:
  - 0 NOP: no state change.
  - 1 LOAD: reg[dst] <= bus_in.
  - 2 DRIVE: bus_out = reg[src], bus_oe = 1. Both are combinational in the same cycle.
  - 3 INC: reg[dst] <= reg[dst] + 1, modulo 2**DATA_WIDTH.
  - 4 DEC: reg[dst] <= reg[dst] - 1, modulo 2**DATA_WIDTH.
  - 5 CLR: reg[dst] <= 0.
  - 6 MOVE: reg[dst] <= reg[src]; does not use the bus.
  - 7 SWAP: reg[dst] <= reg[src] and reg[src] <= reg[dst] on the same edge. dst==src is a no-op.
- Latency: write effects become visible on a_direct, b_direct and DRIVE in the cycle after the edge. There is no write-to-read bypass.
- bus_oe is 0 for every op other than DRIVE. When bus_oe==0, bus_out is 0.
- Flags:
  - Updated only by LOAD, INC, DEC, CLR and MOVE; held on NOP, DRIVE and SWAP.
  - zero_flag = (written value == 0). CLR sets zero_flag=1.
  - carry_flag = 1 on INC from all-ones, or on DEC from 0; otherwise 0 on any flag-updating op.
  - With ZERO_REG0=1 and dst==0, flags are computed from the discarded result.
- Index range:
  - An index >= NUM_REGS on a used operand discards the write and reads 0.
  - Out-of-range a_sel/b_sel read 0 but do not raise idx_err.
  - For any op except NOP: idx_err <= 1 on the next edge when dst (ops 1,3,4,5,6,7) or src (ops 2,6,7) is out of range; otherwise idx_err <= 0.
- ZERO_REG0=1: reg[0] always reads 0 on every read path. A SWAP with reg 0 writes 0 into the other register.
- A single write port plus the SWAP pair; no other simultaneous-write cases exist.

Test Plan:
- Reset/load/read (defaults): reset=0 for 2 cycles -> all outputs 0. LOAD dst=2 bus_in=0xA5, then a_sel=2 -> a_direct=0xA5, zero_flag=0.
- Increment wrap: LOAD r1=0xFF; INC r1 -> r1=0x00, zero_flag=1, carry_flag=1. INC again -> r1=0x01, both flags 0.
- Decrement borrow: CLR r3 -> zero_flag=1. DEC r3 -> r3=0xFF, carry_flag=1, zero_flag=0.
- Drive and swap: r0=0x11, r1=0x22. SWAP dst=0 src=1 -> r0=0x22, r1=0x11, flags unchanged. DRIVE src=1 -> bus_out=0x11, bus_oe=1 the same cycle; bus_oe=0 on the following NOP.
- Range error and ZERO_REG0 (NUM_REGS=3, ZERO_REG0=1): LOAD dst=3 bus_in=0x55 -> no register changes, idx_err=1 for exactly one cycle. LOAD dst=0 bus_in=0x7 -> a_sel=0 reads 0.
- Reset mid-operation: r2=0x40, issue INC r2 with reset=0 on the same edge -> r2=0x00, flags 0. After release, b_sel=2 -> b_direct=0x00.
